// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe
//   Registered immediate generator for the multicycle RISC-V core. Decodes the
//   base immediate formats plus CSR zimm and shift amounts, extends them to XLEN
//   on the input side, and holds the results in a 2-entry valid/ready skid
//   buffer so that decode can be back-pressured without losing instructions.
//
// Parameters
//   XLEN      output width, 32 or 64
//   TAGW      width of the side-band tag carried with each immediate
//
// Ports
//   clk           clock, all state changes on the rising edge
//   reset_n       synchronous active-low reset
//   flush         synchronous clear of buffered entries (data kept)
//   in_valid      input entry present
//   in_ready      block can accept an entry (registered state only)
//   in_instr      instruction bits [31:7]
//   in_immsrc     format select: I,S,B,J,U,Zimm,Shamt,illegal (000..111)
//   in_tag        side-band tag
//   out_valid     head entry valid
//   out_ready     consumer takes the head entry
//   out_imm       extended immediate of the head entry
//   out_illegal   head entry had in_immsrc = 3'b111
//   out_tag       tag of the head entry
//
// state | meaning
// ------+-----------------------------------------------
// EMPTY | no entries buffered
// ONE   | head valid, skid empty
// TWO   | head and skid valid, input stalled

module imm_extend_pipe #(
    parameter int XLEN = 32,
    parameter int TAGW = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [24:0]     in_instr,
    input  logic [2:0]      in_immsrc,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal,
    output logic [TAGW-1:0] out_tag
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [XLEN-1:0] head_imm_q, head_imm_d, skid_imm_q, skid_imm_d;
    logic            head_ill_q, head_ill_d, skid_ill_q, skid_ill_d;
    logic [TAGW-1:0] head_tag_q, head_tag_d, skid_tag_q, skid_tag_d;

    // Re-index the partial instruction so slices use architectural bit numbers.
    logic [31:7]     instr;
    logic [XLEN-1:0] new_imm;
    logic            new_ill;
    logic            push, pop;

    assign instr = in_instr;

    // Signed size casts perform the sign extension to XLEN, including the
    // upper 32 bits of U-type when XLEN = 64.
    always_comb begin
        new_imm = '0;
        new_ill = 1'b0;
        case (in_immsrc)
            3'b000: new_imm = XLEN'($signed(instr[31:20]));
            3'b001: new_imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            3'b010: new_imm = XLEN'($signed({instr[31], instr[7], instr[30:25],
                                             instr[11:8], 1'b0}));
            3'b011: new_imm = XLEN'($signed({instr[31], instr[19:12], instr[20],
                                             instr[30:21], 1'b0}));
            3'b100: new_imm = XLEN'($signed({instr[31:12], 12'b0}));
            3'b101: new_imm = XLEN'(instr[19:15]);
            3'b110: new_imm = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
            default: begin
                new_imm = '0;
                new_ill = 1'b1;
            end
        endcase
    end

    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_d    = state_q;
        head_imm_d = head_imm_q;
        head_ill_d = head_ill_q;
        head_tag_d = head_tag_q;
        skid_imm_d = skid_imm_q;
        skid_ill_d = skid_ill_q;
        skid_tag_d = skid_tag_q;
        if (flush) begin
            // Only occupancy is cleared; stale data stays in the registers.
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d    = ONE;
                        head_imm_d = new_imm;
                        head_ill_d = new_ill;
                        head_tag_d = in_tag;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        state_d    = TWO;
                        skid_imm_d = new_imm;
                        skid_ill_d = new_ill;
                        skid_tag_d = in_tag;
                    end else if (push && pop) begin
                        head_imm_d = new_imm;
                        head_ill_d = new_ill;
                        head_tag_d = in_tag;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_d    = ONE;
                        head_imm_d = skid_imm_q;
                        head_ill_d = skid_ill_q;
                        head_tag_d = skid_tag_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= EMPTY;
            head_imm_q <= '0;
            head_ill_q <= 1'b0;
            head_tag_q <= '0;
            skid_imm_q <= '0;
            skid_ill_q <= 1'b0;
            skid_tag_q <= '0;
        end else begin
            state_q    <= state_d;
            head_imm_q <= head_imm_d;
            head_ill_q <= head_ill_d;
            head_tag_q <= head_tag_d;
            skid_imm_q <= skid_imm_d;
            skid_ill_q <= skid_ill_d;
            skid_tag_q <= skid_tag_d;
        end
    end

    assign out_imm     = head_imm_q;
    assign out_illegal = head_ill_q;
    assign out_tag     = head_tag_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        reset_n, flush, in_valid, out_ready;
    logic [31:0] instr32;
    logic [2:0]  in_immsrc;
    logic [7:0]  in_tag;

    logic        in_ready, out_valid, out_illegal;
    logic [31:0] out_imm;
    logic [7:0]  out_tag;

    logic        in_ready64, out_valid64, out_illegal64;
    logic [63:0] out_imm64;
    logic [7:0]  out_tag64;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    imm_extend_pipe #(.XLEN(32), .TAGW(8)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(instr32[31:7]), .in_immsrc(in_immsrc), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_illegal(out_illegal), .out_tag(out_tag)
    );

    imm_extend_pipe #(.XLEN(64), .TAGW(8)) dut64 (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(instr32[31:7]), .in_immsrc(in_immsrc), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_illegal(out_illegal64), .out_tag(out_tag64)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr32 = 32'h0; in_immsrc = 3'b000; in_tag = 8'h00;
        step();
        step();
        total++;
        if ({out_valid, in_ready, out_imm, out_illegal, out_tag} !== {1'b0, 1'b1, 32'h0, 1'b0, 8'h00}) begin
            bad++;
            $display("FAIL reset: valid=%b ready=%b imm=%h ill=%b tag=%h want 0 1 0 0 0",
                     out_valid, in_ready, out_imm, out_illegal, out_tag);
        end
        total++;
        if ({out_valid64, in_ready64, out_imm64} !== {1'b0, 1'b1, 64'h0}) begin
            bad++;
            $display("FAIL reset64: valid=%b ready=%b imm=%h want 0 1 0",
                     out_valid64, in_ready64, out_imm64);
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_first();
        out_ready = 1'b1;
        in_valid  = 1'b1; instr32 = 32'hFFF00093; in_immsrc = 3'b000; in_tag = 8'h5A;
        step();
        in_valid = 1'b0;
        total++;
        if ({out_valid, out_imm, out_tag, out_illegal} !== {1'b1, 32'hFFFFFFFF, 8'h5A, 1'b0}) begin
            bad++;
            $display("FAIL first_addi: valid=%b imm=%h tag=%h ill=%b want 1 ffffffff 5a 0",
                     out_valid, out_imm, out_tag, out_illegal);
        end
        step();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL first_drain: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_formats();
        logic [31:0] v_ins [10];
        logic [2:0]  v_src [10];
        logic [31:0] v_e32 [10];
        logic [63:0] v_e64 [10];
        logic        v_ill [10];
        v_ins[0] = 32'hFE112E23; v_src[0] = 3'b001; v_e32[0] = 32'hFFFFFFFC; v_e64[0] = 64'hFFFFFFFFFFFFFFFC; v_ill[0] = 0;
        v_ins[1] = 32'hFF9FF06F; v_src[1] = 3'b011; v_e32[1] = 32'hFFFFFFF8; v_e64[1] = 64'hFFFFFFFFFFFFFFF8; v_ill[1] = 0;
        v_ins[2] = 32'h123452B7; v_src[2] = 3'b100; v_e32[2] = 32'h12345000; v_e64[2] = 64'h0000000012345000; v_ill[2] = 0;
        v_ins[3] = 32'h000FD073; v_src[3] = 3'b101; v_e32[3] = 32'h0000001F; v_e64[3] = 64'h000000000000001F; v_ill[3] = 0;
        v_ins[4] = 32'hFFFFFFFF; v_src[4] = 3'b111; v_e32[4] = 32'h00000000; v_e64[4] = 64'h0000000000000000; v_ill[4] = 1;
        v_ins[5] = 32'h800002B7; v_src[5] = 3'b100; v_e32[5] = 32'h80000000; v_e64[5] = 64'hFFFFFFFF80000000; v_ill[5] = 0;
        v_ins[6] = 32'h03F00013; v_src[6] = 3'b110; v_e32[6] = 32'h0000001F; v_e64[6] = 64'h000000000000003F; v_ill[6] = 0;
        v_ins[7] = 32'hFE0008E3; v_src[7] = 3'b010; v_e32[7] = 32'hFFFFFFF0; v_e64[7] = 64'hFFFFFFFFFFFFFFF0; v_ill[7] = 0;
        v_ins[8] = 32'h00000463; v_src[8] = 3'b010; v_e32[8] = 32'h00000008; v_e64[8] = 64'h0000000000000008; v_ill[8] = 0;
        v_ins[9] = 32'h7FF00093; v_src[9] = 3'b000; v_e32[9] = 32'h000007FF; v_e64[9] = 64'h00000000000007FF; v_ill[9] = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; instr32 = v_ins[i]; in_immsrc = v_src[i]; in_tag = 8'(8'h20 + i);
            step();
            total++;
            if ({out_valid, out_imm, out_illegal, out_tag} !== {1'b1, v_e32[i], v_ill[i], 8'(8'h20 + i)}) begin
                bad++;
                $display("FAIL fmt32[%0d]: valid=%b imm=%h ill=%b tag=%h want 1 %h %b %h",
                         i, out_valid, out_imm, out_illegal, out_tag, v_e32[i], v_ill[i], 8'(8'h20 + i));
            end
            total++;
            if ({out_imm64, out_illegal64} !== {v_e64[i], v_ill[i]}) begin
                bad++;
                $display("FAIL fmt64[%0d]: imm=%h ill=%b want %h %b",
                         i, out_imm64, out_illegal64, v_e64[i], v_ill[i]);
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; in_valid = 1'b1; instr32 = 32'h00100093; in_immsrc = 3'b000;
        in_tag = 8'd1;
        step();
        total++;
        if ({in_ready, out_valid, out_tag} !== {1'b1, 1'b1, 8'd1}) begin
            bad++;
            $display("FAIL bp_one: ready=%b valid=%b tag=%h want 1 1 01", in_ready, out_valid, out_tag);
        end
        in_tag = 8'd2;
        step();
        total++;
        if ({in_ready, out_tag} !== {1'b0, 8'd1}) begin
            bad++;
            $display("FAIL bp_two: ready=%b tag=%h want 0 01", in_ready, out_tag);
        end
        in_tag = 8'd3;
        step();
        total++;
        if ({in_ready, out_valid, out_tag} !== {1'b0, 1'b1, 8'd1}) begin
            bad++;
            $display("FAIL bp_stall: ready=%b valid=%b tag=%h want 0 1 01", in_ready, out_valid, out_tag);
        end
        out_ready = 1'b1;
        step();
        total++;
        if ({in_ready, out_valid, out_tag} !== {1'b1, 1'b1, 8'd2}) begin
            bad++;
            $display("FAIL bp_pop1: ready=%b valid=%b tag=%h want 1 1 02", in_ready, out_valid, out_tag);
        end
        step();
        total++;
        if ({out_valid, out_tag} !== {1'b1, 8'd3}) begin
            bad++;
            $display("FAIL bp_pop2: valid=%b tag=%h want 1 03", out_valid, out_tag);
        end
        in_valid = 1'b0;
        step();
        total++;
        if ({out_valid, in_ready} !== {1'b0, 1'b1}) begin
            bad++;
            $display("FAIL bp_drain: valid=%b ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1; in_valid = 1'b1; instr32 = 32'h00500093; in_immsrc = 3'b000;
        in_tag = 8'h40;
        step();
        for (int i = 1; i <= 10; i++) begin
            in_tag = 8'(8'h40 + i);
            step();
            total++;
            if ({in_ready, out_valid, out_tag} !== {1'b1, 1'b1, 8'(8'h40 + i)}) begin
                bad++;
                $display("FAIL b2b[%0d]: ready=%b valid=%b tag=%h want 1 1 %h",
                         i, in_ready, out_valid, out_tag, 8'(8'h40 + i));
            end
        end
        in_valid = 1'b0;
        step();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_drain: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_flush_reset();
        out_ready = 1'b0; in_valid = 1'b1; instr32 = 32'hFFF00093; in_immsrc = 3'b000;
        in_tag = 8'hA1;
        step();
        in_tag = 8'hA2;
        step();
        in_tag = 8'hA3; flush = 1'b1;
        step();
        flush = 1'b0;
        total++;
        if ({out_valid, in_ready, out_tag} !== {1'b0, 1'b1, 8'hA1}) begin
            bad++;
            $display("FAIL flush: valid=%b ready=%b tag=%h want 0 1 a1", out_valid, in_ready, out_tag);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_lost: valid=%b want 0", out_valid);
        end
        out_ready = 1'b0; in_valid = 1'b1; in_tag = 8'hB1;
        step();
        in_tag = 8'hB2;
        step();
        in_tag = 8'hB3; reset_n = 1'b0; flush = 1'b1;
        step();
        total++;
        if ({out_valid, in_ready, out_imm, out_illegal, out_tag} !== {1'b0, 1'b1, 32'h0, 1'b0, 8'h00}) begin
            bad++;
            $display("FAIL midreset: valid=%b ready=%b imm=%h ill=%b tag=%h want 0 1 0 0 0",
                     out_valid, in_ready, out_imm, out_illegal, out_tag);
        end
        reset_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        total++;
        if ({out_valid, out_imm64} !== {1'b0, 64'h0}) begin
            bad++;
            $display("FAIL midreset_after: valid=%b imm64=%h want 0 0", out_valid, out_imm64);
        end
    endtask

    initial begin
        test_reset();
        test_first();
        test_formats();
        test_backpressure();
        test_back_to_back();
        test_flush_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
